// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline MEM stage.
//   mem_state_t : MEM stage access state (idle, data-memory access, bus read)
//   REG_W       : register / datapath width
//   RADDR_W     : register-file address width
package cpu_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_ACC,
        MEM_BUS
    } mem_state_t;

    localparam int REG_W   = 16;
    localparam int RADDR_W = 4;

endpackage

// File: rtl/mem_req_fsm.sv
// Request/acknowledge sequencer for the MEM stage.
//
// state    | meaning
// ---------+-----------------------------------------------
// MEM_IDLE | no access outstanding; start_* launches one
// MEM_ACC  | dmem_req held high until dmem_ack
// MEM_BUS  | bus_req held high until bus_ack
//
// Ports
//   clk, rst_n    : clock, async active-low reset
//   start_mem_i   : launch a data-memory access (wins over start_bus_i)
//   start_bus_i   : launch an accelerator-bus read
//   dmem_ack_i    : data-memory acknowledge
//   bus_ack_i     : accelerator-bus acknowledge
//   state_o       : current state
//   dmem_req_o    : registered data-memory request
//   bus_req_o     : registered bus request
//   done_o        : access completes at this clock edge
//   mem_err_o     : one-cycle timeout pulse
//
// Build option: MEM_TIMEOUT_EN adds an 8-bit wait counter that abandons an
// access after TIMEOUT_CYC unacknowledged cycles. Without it the sequencer
// waits forever and mem_err_o is tied low.
module mem_req_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_mem_i,
    input  logic       start_bus_i,
    input  logic       dmem_ack_i,
    input  logic       bus_ack_i,
    output mem_state_t state_o,
    output logic       dmem_req_o,
    output logic       bus_req_o,
    output logic       done_o,
    output logic       mem_err_o
);

    mem_state_t state_q, state_d;
    logic       dmem_req_q, dmem_req_d;
    logic       bus_req_q, bus_req_d;
    logic       timeout;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q;
    logic       ack_cur;

    // The counter has already seen TIMEOUT_CYC-1 idle cycles, so this is the
    // last allowed wait cycle: request stays high exactly TIMEOUT_CYC cycles.
    assign timeout = (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
    assign ack_cur = (state_q == MEM_ACC) ? dmem_ack_i : bus_ack_i;
    // Entering from IDLE always starts at zero.
    assign wait_cnt_d = (state_q == MEM_IDLE) ? 8'd0 : wait_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= (state_q != MEM_IDLE) && !ack_cur && timeout;
        end
    end

    assign mem_err_o = mem_err_q;
`else
    // Keeps the parameter referenced in the build without a timeout.
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYC);
    assign timeout        = 1'b0;
    assign mem_err_o      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= MEM_IDLE;
            dmem_req_q <= 1'b0;
            bus_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dmem_req_q <= dmem_req_d;
            bus_req_q  <= bus_req_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dmem_req_d = dmem_req_q;
        bus_req_d  = bus_req_q;
        done_o     = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (start_mem_i) begin
                    state_d    = MEM_ACC;
                    dmem_req_d = 1'b1;
                end else if (start_bus_i) begin
                    state_d   = MEM_BUS;
                    bus_req_d = 1'b1;
                end
            end
            MEM_ACC: begin
                if (dmem_ack_i) begin
                    state_d    = MEM_IDLE;
                    dmem_req_d = 1'b0;
                    done_o     = 1'b1;
                end else if (timeout) begin
                    state_d    = MEM_IDLE;
                    dmem_req_d = 1'b0;
                end
            end
            MEM_BUS: begin
                if (bus_ack_i) begin
                    state_d   = MEM_IDLE;
                    bus_req_d = 1'b0;
                    done_o    = 1'b1;
                end else if (timeout) begin
                    state_d   = MEM_IDLE;
                    bus_req_d = 1'b0;
                end
            end
            default: begin
                state_d    = MEM_IDLE;
                dmem_req_d = 1'b0;
                bus_req_d  = 1'b0;
            end
        endcase
    end

    assign state_o    = state_q;
    assign dmem_req_o = dmem_req_q;
    assign bus_req_o  = bus_req_q;

endmodule

// File: rtl/memory_stage.sv
// CPU pipeline MEM stage: data-memory load/store or accelerator-bus read,
// upstream stall while an access is outstanding, forwarding back to execute
// and the registered writeback result for WB.
//
// Ports
//   clk, rst_n                 : clock, async active-low reset
//   ex_*                       : registered control/data from execute
//   mem_regwrite/memread/
//   mem_regwraddr/regwrdata    : forwarding to execute (combinational)
//   mem_stall                  : freeze PC/IF/ID/EX
//   dmem_req/we/addr/wdata     : data-memory request side (registered)
//   dmem_rdata, dmem_ack       : data-memory response
//   bus_req/addr               : accelerator-bus request side (registered)
//   bus_rdata, bus_ack         : accelerator-bus response
//   wb_regwrite/regwraddr/
//   wb_regwrdata               : registered writeback result
//   mem_err                    : one-cycle timeout pulse
//
// Build option: MEM_TIMEOUT_EN enables the access timeout in mem_req_fsm.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int DMEM_AW     = 16,
    parameter int BUS_AW      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_regwrite,
    input  logic               ex_memtoreg,
    input  logic               ex_bustoreg,
    input  logic               ex_memread,
    input  logic               ex_memwrite,
    input  logic [REG_W-1:0]   ex_alu_out,
    input  logic [REG_W-1:0]   ex_alu_src2,
    input  logic [RADDR_W-1:0] ex_regwraddr,
    output logic               mem_regwrite,
    output logic               mem_memread,
    output logic [RADDR_W-1:0] mem_regwraddr,
    output logic [REG_W-1:0]   mem_regwrdata,
    output logic               mem_stall,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [REG_W-1:0]   dmem_wdata,
    input  logic [REG_W-1:0]   dmem_rdata,
    input  logic               dmem_ack,
    output logic               bus_req,
    output logic [BUS_AW-1:0]  bus_addr,
    input  logic [REG_W-1:0]   bus_rdata,
    input  logic               bus_ack,
    output logic               wb_regwrite,
    output logic [RADDR_W-1:0] wb_regwraddr,
    output logic [REG_W-1:0]   wb_regwrdata,
    output logic               mem_err
);

    mem_state_t         state;
    logic               idle, done, start_mem, access;

    logic               cap_regwrite_q, cap_memtoreg_q, cap_bustoreg_q, cap_memwrite_q;
    logic [RADDR_W-1:0] cap_regwraddr_q;
    logic [REG_W-1:0]   cap_alu_q;
    logic [DMEM_AW-1:0] dmem_addr_q;
    logic [REG_W-1:0]   dmem_wdata_q;
    logic [BUS_AW-1:0]  bus_addr_q;
    logic               wb_regwrite_q;
    logic [RADDR_W-1:0] wb_regwraddr_q;
    logic [REG_W-1:0]   wb_regwrdata_q, wb_data_d;

    assign idle      = (state == MEM_IDLE);
    assign start_mem = ex_memread | ex_memwrite;
    assign access    = start_mem | ex_bustoreg;
    // Stall combinationally on a new access so EX holds the op during capture.
    assign mem_stall = !idle || access;

    mem_req_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_req_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_mem_i (start_mem),
        .start_bus_i (ex_bustoreg),
        .dmem_ack_i  (dmem_ack),
        .bus_ack_i   (bus_ack),
        .state_o     (state),
        .dmem_req_o  (dmem_req),
        .bus_req_o   (bus_req),
        .done_o      (done),
        .mem_err_o   (mem_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_regwrite_q  <= 1'b0;
            cap_memtoreg_q  <= 1'b0;
            cap_bustoreg_q  <= 1'b0;
            cap_memwrite_q  <= 1'b0;
            cap_regwraddr_q <= '0;
            cap_alu_q       <= '0;
            dmem_addr_q     <= '0;
            dmem_wdata_q    <= '0;
            bus_addr_q      <= '0;
        end else if (idle) begin
            cap_regwrite_q  <= ex_regwrite;
            cap_memtoreg_q  <= ex_memtoreg;
            cap_bustoreg_q  <= ex_bustoreg;
            cap_memwrite_q  <= ex_memwrite;
            cap_regwraddr_q <= ex_regwraddr;
            cap_alu_q       <= ex_alu_out;
            if (start_mem) begin
                dmem_addr_q  <= ex_alu_out[DMEM_AW-1:0];
                dmem_wdata_q <= ex_alu_src2;
            end else if (ex_bustoreg) begin
                bus_addr_q   <= ex_alu_out[BUS_AW-1:0];
            end
        end
    end

    always_comb begin
        wb_data_d = cap_alu_q;
        if (cap_memtoreg_q)
            wb_data_d = dmem_rdata;
        else if (cap_bustoreg_q)
            wb_data_d = bus_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwrite_q  <= 1'b0;
            wb_regwraddr_q <= '0;
            wb_regwrdata_q <= '0;
        end else if (idle) begin
            // An access launching this cycle sends a bubble to WB.
            wb_regwrite_q  <= ex_regwrite && !access;
            wb_regwraddr_q <= ex_regwraddr;
            wb_regwrdata_q <= ex_alu_out;
        end else if (done) begin
            wb_regwrite_q  <= cap_regwrite_q && !cap_memwrite_q;
            wb_regwraddr_q <= cap_regwraddr_q;
            wb_regwrdata_q <= wb_data_d;
        end else begin
            wb_regwrite_q  <= 1'b0;
        end
    end

    // Write strobe follows the request so it drops with it on ack or timeout.
    assign dmem_we       = dmem_req && cap_memwrite_q;
    assign dmem_addr     = dmem_addr_q;
    assign dmem_wdata    = dmem_wdata_q;
    assign bus_addr      = bus_addr_q;

    assign mem_regwrite  = ex_regwrite;
    assign mem_memread   = ex_memread;
    assign mem_regwraddr = ex_regwraddr;
    assign mem_regwrdata = ex_alu_out;

    assign wb_regwrite   = wb_regwrite_q;
    assign wb_regwraddr  = wb_regwraddr_q;
    assign wb_regwrdata  = wb_regwrdata_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

    logic        clk, rst_n;
    logic        ex_regwrite, ex_memtoreg, ex_bustoreg, ex_memread, ex_memwrite;
    logic [15:0] ex_alu_out, ex_alu_src2;
    logic [3:0]  ex_regwraddr;
    logic        mem_regwrite, mem_memread, mem_stall;
    logic [3:0]  mem_regwraddr;
    logic [15:0] mem_regwrdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        bus_req, bus_ack;
    logic [7:0]  bus_addr;
    logic [15:0] bus_rdata;
    logic        wb_regwrite, mem_err;
    logic [3:0]  wb_regwraddr;
    logic [15:0] wb_regwrdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [15:0] data;
    } wb_t;
    wb_t sb[$];

    memory_stage #(
        .DMEM_AW     (16),
        .BUS_AW      (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_regwrite   (ex_regwrite),
        .ex_memtoreg   (ex_memtoreg),
        .ex_bustoreg   (ex_bustoreg),
        .ex_memread    (ex_memread),
        .ex_memwrite   (ex_memwrite),
        .ex_alu_out    (ex_alu_out),
        .ex_alu_src2   (ex_alu_src2),
        .ex_regwraddr  (ex_regwraddr),
        .mem_regwrite  (mem_regwrite),
        .mem_memread   (mem_memread),
        .mem_regwraddr (mem_regwraddr),
        .mem_regwrdata (mem_regwrdata),
        .mem_stall     (mem_stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .bus_req       (bus_req),
        .bus_addr      (bus_addr),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack),
        .wb_regwrite   (wb_regwrite),
        .wb_regwraddr  (wb_regwraddr),
        .wb_regwrdata  (wb_regwrdata),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nop();
        ex_regwrite  = 1'b0;
        ex_memtoreg  = 1'b0;
        ex_bustoreg  = 1'b0;
        ex_memread   = 1'b0;
        ex_memwrite  = 1'b0;
        ex_alu_out   = 16'h0000;
        ex_alu_src2  = 16'h0000;
        ex_regwraddr = 4'd0;
    endtask

    task automatic drive(input logic rw, mtr, btr, mrd, mwr,
                         input logic [3:0] rd, input logic [15:0] alu, src2);
        ex_regwrite  = rw;
        ex_memtoreg  = mtr;
        ex_bustoreg  = btr;
        ex_memread   = mrd;
        ex_memwrite  = mwr;
        ex_regwraddr = rd;
        ex_alu_out   = alu;
        ex_alu_src2  = src2;
    endtask

    task automatic chk_wb(input string tag);
        wb_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_wbwe"}, 32'(wb_regwrite), 32'(e.we));
            if (e.we) begin
                chk({tag, "_wbrd"}, 32'(wb_regwraddr), 32'(e.rd));
                chk({tag, "_wbdata"}, 32'(wb_regwrdata), 32'(e.data));
            end
        end
    endtask

    // Single-cycle ALU op driven at a negedge; WB result one edge later.
    task automatic alu_op(input string tag, input logic [3:0] rd, input logic [15:0] alu);
        wb_t e;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rd, alu, 16'h0000);
        e.we = 1'b1; e.rd = rd; e.data = alu;
        sb.push_back(e);
        #1;
        chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
        chk({tag, "_fwd"}, {11'd0, mem_regwrite, mem_regwraddr, mem_regwrdata},
            {11'd0, 1'b1, rd, alu});
        @(negedge clk);
        nop();
        #1;
        chk({tag, "_stall1"}, 32'(mem_stall), 32'd0);
        chk_wb(tag);
    endtask

    // Access whose ack arrives in the nreq-th request cycle. Meanwhile the
    // other handshake's ack is pulsed and ex_* carry junk; both must be ignored.
    task automatic do_access(input string tag, input logic rw, mtr, btr, mrd, mwr,
                             input logic [3:0] rd, input logic [15:0] alu, src2, rdata,
                             input int nreq);
        wb_t e;
        logic use_bus;
        use_bus = btr && !(mrd || mwr);
        drive(rw, mtr, btr, mrd, mwr, rd, alu, src2);
        e.we   = rw && !mwr;
        e.rd   = rd;
        e.data = (mtr || btr) ? rdata : alu;
        sb.push_back(e);
        #1;
        chk({tag, "_stall0"}, 32'(mem_stall), 32'd1);
        chk({tag, "_req0"}, {dmem_req, bus_req}, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 16'hDEAD, 16'hDEAD);
        for (int k = 1; k <= nreq; k++) begin
            #1;
            chk($sformatf("%s_req%0d", tag, k), {dmem_req, bus_req}, {!use_bus, use_bus});
            chk($sformatf("%s_stall%0d", tag, k), 32'(mem_stall), 32'd1);
            chk($sformatf("%s_bubble%0d", tag, k), 32'(wb_regwrite), 32'd0);
            if (use_bus) begin
                chk($sformatf("%s_baddr%0d", tag, k), 32'(bus_addr), 32'(alu[7:0]));
            end else begin
                chk($sformatf("%s_daddr%0d", tag, k), 32'(dmem_addr), 32'(alu));
                chk($sformatf("%s_we%0d", tag, k), 32'(dmem_we), 32'(mwr));
                if (mwr) chk($sformatf("%s_wdata%0d", tag, k), 32'(dmem_wdata), 32'(src2));
            end
            if (k == nreq) begin
                dmem_ack   = !use_bus;
                bus_ack    = use_bus;
                dmem_rdata = use_bus ? ~rdata : rdata;
                bus_rdata  = use_bus ? rdata : ~rdata;
            end else begin
                dmem_ack   = use_bus;
                bus_ack    = !use_bus;
                dmem_rdata = ~rdata;
                bus_rdata  = ~rdata;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
            bus_ack  = 1'b0;
        end
        nop();
        #1;
        chk({tag, "_reqend"}, {dmem_req, bus_req, dmem_we}, 32'd0);
        chk({tag, "_stallend"}, 32'(mem_stall), 32'd0);
        chk_wb(tag);
    endtask

    initial begin
        nop();
        dmem_ack   = 1'b0;
        bus_ack    = 1'b0;
        dmem_rdata = 16'h0000;
        bus_rdata  = 16'h0000;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", {dmem_req, dmem_we, bus_req, wb_regwrite, mem_err, mem_stall}, 32'd0);
        chk("rst_addr", {dmem_addr, 8'd0, bus_addr}, 32'd0);
        chk("rst_wb", {12'd0, wb_regwraddr, wb_regwrdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        alu_op("alu", 4'd3, 16'h1234);

        // Ack while no request is outstanding.
        dmem_ack = 1'b1;
        bus_ack  = 1'b1;
        alu_op("stray_ack", 4'd5, 16'h0055);
        chk("stray_req", {dmem_req, bus_req}, 32'd0);
        dmem_ack = 1'b0;
        bus_ack  = 1'b0;

        do_access("load", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 16'h0040, 16'h0000, 16'hBEEF, 3);
        do_access("store", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h0010, 16'h00AA, 16'h0000, 2);
        do_access("bus", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0105, 16'h0000, 16'h7F00, 2);
        do_access("bus_min", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 16'h02A7, 16'h0000, 16'h0C3C, 1);
        do_access("prio", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 16'h0200, 16'h0000, 16'h1111, 1);
        alu_op("r0", 4'd0, 16'hA5A5);

        // Async reset in the middle of a store.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'h0077, 16'h5555);
        @(negedge clk);
        nop();
        #1;
        chk("rstmid_pre", {dmem_req, dmem_we}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out", {dmem_req, dmem_we, bus_req, wb_regwrite, mem_stall}, 32'd0);
        chk("rstmid_addr", 32'(dmem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        alu_op("post_rst", 4'd8, 16'h4321);

`ifdef MEM_TIMEOUT_EN
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10, 16'h0080, 16'h0000);
        @(negedge clk);
        nop();
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("tmo_req%0d", k), {dmem_req, mem_err}, 32'd2);
            @(negedge clk);
        end
        #1;
        chk("tmo_drop", {dmem_req, mem_err, wb_regwrite, mem_stall}, 32'b0100);
        @(negedge clk);
        #1;
        chk("tmo_pulse", {mem_err, wb_regwrite}, 32'd0);
        alu_op("post_tmo", 4'd11, 16'h0F0F);
`else
        #1;
        chk("no_err", 32'(mem_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
